// File: rtl/mult_err_stats.sv
// Error-statistics checker for an 8x8 approximate multiplier: error count, saturating |error| sum, max |error|.
// Define MULT_ERR_BIAS_EN to add the signed error-bias accumulator output err_bias.
module mult_err_stats #(
    parameter int WIDTH    = 8,
    parameter int OUTWIDTH = 16,
    parameter int NSAMPLES = 256,
    parameter int CNTW     = 16,
    parameter int ACCW     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    IN1,
    input  logic [WIDTH-1:0]    IN2,
    input  logic [OUTWIDTH-1:0] P,
    output logic                done,
    output logic [CNTW-1:0]     sample_cnt,
    output logic [CNTW-1:0]     err_cnt,
    output logic [ACCW-1:0]     sum_abs_err,
    output logic [OUTWIDTH-1:0] max_abs_err
`ifdef MULT_ERR_BIAS_EN
    ,
    output logic [ACCW-1:0]     err_bias
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    function automatic logic [ACCW-1:0] sat_add_u(input logic [ACCW-1:0] a,
                                                   input logic [OUTWIDTH-1:0] b);
        logic [ACCW:0] s;
        s = {1'b0, a} + (ACCW+1)'(b);
        return s[ACCW] ? {ACCW{1'b1}} : s[ACCW-1:0];
    endfunction

    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] a);
        return (a == {CNTW{1'b1}}) ? a : a + 1'b1;
    endfunction

    function automatic logic signed [ACCW-1:0] sat_add_s(input logic signed [ACCW-1:0] a,
                                                          input logic signed [OUTWIDTH:0] b);
        logic signed [ACCW:0] s;
        s = a + b;
        if (s[ACCW] != s[ACCW-1])
            return s[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}};
        return s[ACCW-1:0];
    endfunction

    state_t                r_state;
    logic                  r_in_ready;
    logic                  r_done;
    logic                  r_vld_p1;
    logic [OUTWIDTH-1:0]   r_exact_p1;
    logic [OUTWIDTH-1:0]   r_prod_p1;
    logic [CNTW-1:0]       r_sample_cnt;
    logic [CNTW-1:0]       r_err_cnt;
    logic [ACCW-1:0]       r_sum_abs_p2;
    logic [OUTWIDTH-1:0]   r_max_abs_p2;

    logic                  w_accept;
    logic                  w_last;
    logic [OUTWIDTH-1:0]   w_exact;
    logic [OUTWIDTH-1:0]   w_abs_diff;

    assign w_accept   = in_valid & r_in_ready;
    assign w_last     = (r_sample_cnt == CNTW'(NSAMPLES - 1));
    assign w_exact    = OUTWIDTH'(IN1) * OUTWIDTH'(IN2);
    assign w_abs_diff = (r_exact_p1 >= r_prod_p1) ? (r_exact_p1 - r_prod_p1)
                                                  : (r_prod_p1 - r_exact_p1);

`ifdef MULT_ERR_BIAS_EN
    logic signed [ACCW-1:0]   r_bias_p2;
    logic signed [OUTWIDTH:0] w_err_s;
    assign w_err_s  = $signed({1'b0, r_prod_p1}) - $signed({1'b0, r_exact_p1});
    assign err_bias = r_bias_p2;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_in_ready   <= 1'b0;
            r_done       <= 1'b0;
            r_vld_p1     <= 1'b0;
            r_exact_p1   <= '0;
            r_prod_p1    <= '0;
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_sum_abs_p2 <= '0;
            r_max_abs_p2 <= '0;
`ifdef MULT_ERR_BIAS_EN
            r_bias_p2    <= '0;
`endif
        end else begin
            // S1: capture exact and approximate products on acceptance
            r_vld_p1 <= w_accept;
            if (w_accept) begin
                r_exact_p1   <= w_exact;
                r_prod_p1    <= P;
                r_sample_cnt <= r_sample_cnt + 1'b1;
            end

            // S2: fold the error distance into the statistics
            if (r_vld_p1) begin
                if (w_abs_diff != '0)
                    r_err_cnt <= sat_inc(r_err_cnt);
                r_sum_abs_p2 <= sat_add_u(r_sum_abs_p2, w_abs_diff);
                if (w_abs_diff > r_max_abs_p2)
                    r_max_abs_p2 <= w_abs_diff;
`ifdef MULT_ERR_BIAS_EN
                r_bias_p2 <= sat_add_s(r_bias_p2, w_err_s);
`endif
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_in_ready   <= 1'b1;
                        r_done       <= 1'b0;
                        r_sample_cnt <= '0;
                        r_err_cnt    <= '0;
                        r_sum_abs_p2 <= '0;
                        r_max_abs_p2 <= '0;
`ifdef MULT_ERR_BIAS_EN
                        r_bias_p2    <= '0;
`endif
                    end
                end
                S_RUN: begin
                    if (w_accept && w_last) begin
                        r_state    <= S_DRAIN;
                        r_in_ready <= 1'b0;
                    end
                end
                S_DRAIN: begin
                    // The S1 slot empties one cycle after the last acceptance
                    if (!r_vld_p1) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_done     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign done        = r_done;
    assign sample_cnt  = r_sample_cnt;
    assign err_cnt     = r_err_cnt;
    assign sum_abs_err = r_sum_abs_p2;
    assign max_abs_err = r_max_abs_p2;

endmodule
